// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-cycle SRAM controller
// port between NUM_REQ bus masters, plus the MBIST and retention sequencer
// for that controller.
//
// Optional feature macro: ARB_AGING_EN
//   When defined, a per-requester wait counter forces a grant to the lowest
//   requester whose wait has reached AGE_LIMIT cycles, overriding round-robin.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   m_req/m_we/m_be/    per-requester request and fields, packed by index
//   m_addr/m_wdata
//   m_gnt               one-hot grant (same cycle as the request)
//   m_rvalid/m_rdata    read return, one cycle after the read grant
//   sram_*              controller request port (fields zero when idle)
//   sram_rdata/ready    controller read data (combinational) and ready
//   mbist_start         level request for an MBIST run (edge-armed)
//   mbist_en/done/fail/ controller MBIST handshake
//   mbist_fail_addr
//   bist_done/fail/     run-complete pulse, sticky result, failing address
//   bist_fail_addr
//   sleep_req/sleep_ack retention request / acknowledge
//   ret_en              controller retention enable
module sram_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned AGE_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            m_req,
  input  logic [NUM_REQ-1:0]            m_we,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] m_be,
  input  logic [NUM_REQ*ADDR_W-1:0]     m_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     m_wdata,
  output logic [NUM_REQ-1:0]            m_gnt,
  output logic [NUM_REQ-1:0]            m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          sram_req,
  output logic                          sram_we,
  output logic [DATA_W/8-1:0]           sram_be,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_wdata,
  input  logic [DATA_W-1:0]             sram_rdata,
  input  logic                          sram_ready,
  input  logic                          mbist_start,
  output logic                          mbist_en,
  input  logic                          mbist_done,
  input  logic                          mbist_fail,
  input  logic [ADDR_W-1:0]             mbist_fail_addr,
  output logic                          bist_done,
  output logic                          bist_fail,
  output logic [ADDR_W-1:0]             bist_fail_addr,
  input  logic                          sleep_req,
  output logic                          sleep_ack,
  output logic                          ret_en
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time parameter sanity check.
  if (NUM_REQ < 2 || NUM_REQ > 8 || AGE_LIMIT == 0 || (DATA_W % 8) != 0) begin : g_param_check
    $error("sram_arbiter: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
    ST_MBIST     = 3'd1,
    ST_MBIST_END = 3'd2,
    ST_RET       = 3'd3,
    ST_WAKE      = 3'd4
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic               armed;
  logic               mode_go;
  logic               gnt_en;
  logic               win_we;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   rr_idx;
  logic               rr_found;
  int unsigned        cand;
  logic [NUM_REQ-1:0] gnt_vec;

  // A mode request sampled in ARB blocks that cycle's grant.
  assign mode_go = (state == ST_ARB) && (sleep_req || (mbist_start && armed));
  assign gnt_en  = (state == ST_ARB) && !mode_go && sram_ready && (|m_req);

  // Round-robin: first requester at or after the pointer, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && m_req[cand[PTR_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[PTR_W-1:0];
      end
    end
  end

`ifdef ARB_AGING_EN
  localparam int unsigned CNT_W = $clog2(AGE_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt [NUM_REQ];
  logic             age_found;
  logic [PTR_W-1:0] age_idx;

  // Lowest-index requester whose wait has reached the limit.
  always_comb begin
    age_found = 1'b0;
    age_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!age_found && m_req[i] && (wait_cnt[i] >= CNT_W'(AGE_LIMIT))) begin
        age_found = 1'b1;
        age_idx   = PTR_W'(i);
      end
    end
  end

  always_comb win = age_found ? age_idx : rr_idx;

  // Wait counters saturate at the limit and clear on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_vec[i]) begin
          wait_cnt[i] <= '0;
        end else if ((state == ST_ARB) && m_req[i] && (wait_cnt[i] != CNT_W'(AGE_LIMIT))) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  always_comb win = rr_idx;
`endif

  // Grant vector and controller field mux; fields are zero when idle.
  always_comb begin
    gnt_vec    = '0;
    win_we     = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt_en) gnt_vec[win] = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_vec[i]) begin
        win_we     = m_we[i];
        sram_we    = m_we[i];
        sram_be    = m_be[i*BE_W +: BE_W];
        sram_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sram_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign m_gnt    = gnt_vec;
  assign sram_req = gnt_en;

  // Read return: capture on the grant edge, pulse valid the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid <= '0;
      m_rdata  <= '0;
    end else begin
      m_rvalid <= (gnt_en && !win_we) ? gnt_vec : '0;
      if (gnt_en && !win_we) m_rdata <= sram_rdata;
    end
  end

  // Mode sequencer with registered mode outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_ARB;
      ptr            <= '0;
      armed          <= 1'b1;
      mbist_en       <= 1'b0;
      bist_done      <= 1'b0;
      bist_fail      <= 1'b0;
      bist_fail_addr <= '0;
      sleep_ack      <= 1'b0;
      ret_en         <= 1'b0;
    end else begin
      bist_done <= 1'b0;
      if (gnt_en) begin
        ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
      end
      case (state)
        ST_ARB: begin
          if (!mbist_start) armed <= 1'b1;
          if (sleep_req) begin
            state     <= ST_RET;
            ret_en    <= 1'b1;
            sleep_ack <= 1'b1;
          end else if (mbist_start && armed) begin
            state    <= ST_MBIST;
            armed    <= 1'b0;
            mbist_en <= 1'b1;
          end
        end
        ST_MBIST: begin
          if (mbist_done) begin
            state          <= ST_MBIST_END;
            mbist_en       <= 1'b0;
            bist_done      <= 1'b1;
            bist_fail      <= mbist_fail;
            bist_fail_addr <= mbist_fail ? mbist_fail_addr : '0;
          end
        end
        ST_MBIST_END: state <= ST_ARB;
        ST_RET: begin
          if (!sleep_req) begin
            state     <= ST_WAKE;
            ret_en    <= 1'b0;
            sleep_ack <= 1'b0;
          end
        end
        ST_WAKE: state <= ST_ARB;
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-cycle SRAM controller port between NUM_REQ requesters, e.g. core instruction fetch, core data and DMA.
- Sequences the controller's maintenance modes: MBIST runs and retention entry/exit.
- Sits between the bus-side masters and the SRAM controller. It owns the controller's req/we/be/addr/wdata, mbist_en and ret_en inputs.
- Arbitration is round-robin. Read data is registered and returned with a per-requester valid pulse.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 13, SRAM byte-address width.
- DATA_W, 32, data width (byte enables = DATA_W/8).
- AGE_LIMIT, 16, wait cycles before aging escalation (only with ARB_AGING_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req  in  NUM_REQ  per-requester request; held with its fields until granted
- m_we  in  NUM_REQ  per-requester write enable
- m_be  in  4*NUM_REQ  byte enables; requester i occupies slice [4i+3:4i]
- m_addr  in  ADDR_W*NUM_REQ  byte addresses, packed by index
- m_wdata  in  DATA_W*NUM_REQ  write data, packed by index
- m_gnt  out  NUM_REQ  one-hot grant; transfer completes at the posedge where gnt=1
- m_rvalid  out  NUM_REQ  one-cycle read-return pulse to the granted reader
- m_rdata  out  DATA_W  registered read data, shared by all requesters
- sram_req  out  1  to controller
- sram_we  out  1  to controller
- sram_be  out  4  to controller
- sram_addr  out  ADDR_W  to controller
- sram_wdata  out  DATA_W  to controller
- sram_rdata  in  DATA_W  combinational read data from controller
- sram_ready  in  1  controller ready
- mbist_start  in  1  level; request an MBIST run
- mbist_en  out  1  to controller
- mbist_done  in  1  from controller
- mbist_fail  in  1  from controller
- mbist_fail_addr  in  ADDR_W  from controller
- bist_done  out  1  one-cycle pulse when a run finishes
- bist_fail  out  1  sticky result of the last run
- bist_fail_addr  out  ADDR_W  captured failing address
- sleep_req  in  1  level; request retention
- sleep_ack  out  1  high while in retention
- ret_en  out  1  to controller

Behaviour:
- Reset values:
  - Every output is 0.
  - The round-robin pointer is 0 and the state is ARB.
  - An asynchronous reset during MBIST or RET drops mbist_en and ret_en immediately.
- States: ARB, MBIST, MBIST_END, RET, WAKE.
- ARB:
  - When sram_ready=1 and any m_req is high, grant the first requesting index at or after the pointer, wrapping around modulo NUM_REQ.
  - The grant is combinational in the same cycle. Controller fields are muxed from the winner and sram_req=1.
  - After the grant edge, the pointer becomes winner+1 (mod NUM_REQ).
  - When sram_ready=0, issue no grant.
- Read return:
  - On the grant edge of a read, capture sram_rdata into m_rdata.
  - m_rvalid[winner] pulses in the next cycle, giving 1-cycle latency.
  - Writes produce no rvalid.
  - m_rdata holds its value until the next read.
  - Back-to-back grants every cycle are supported.
- Mode requests from ARB:
  - sleep_req=1 has priority and moves to RET. Otherwise mbist_start=1 moves to MBIST.
  - No grant is issued in the cycle the mode request is sampled.
  - A pending m_rvalid still fires.
- MBIST:
  - m_gnt=0, sram_req=0, mbist_en=1.
  - When mbist_done=1, latch bist_fail=mbist_fail and bist_fail_addr=mbist_fail_addr (or 0 if the run passed), then go to MBIST_END.
  - sleep_req is ignored in MBIST.
- MBIST_END:
  - mbist_en=0 and bist_done=1 for one cycle, then go to ARB.
  - A still-high mbist_start does not retrigger until it has been seen low in ARB; this is edge-armed.
- RET:
  - ret_en=1, sleep_ack=1, no grants.
  - When sleep_req=0, go to WAKE.
- WAKE:
  - ret_en=0, sleep_ack=0, no grants for one cycle, then go to ARB.
- Requests held during MBIST/RET/WAKE are not lost. They are arbitrated on return to ARB, and the pointer is unchanged.
- Fields of non-granted requesters are don't-care. sram_we, sram_be, sram_addr and sram_wdata are 0 when sram_req=0.

Optional Feature:
- ARB_AGING_EN:
  - When defined, each requester has a wait counter. It increments every ARB cycle the requester is requesting but not granted, and clears on its grant.
  - Any counter >= AGE_LIMIT forces a grant to the lowest such index, overriding round-robin. The pointer then updates normally.
  - When undefined, there are no counters and arbitration is pure round-robin.

Test Plan:
- Round-robin:
  - Stimulus: m_req=3'b111 held for 6 cycles, all reads, pointer starting at 0.
  - Required response: grants 0,1,2,0,1,2. Each m_rvalid arrives 1 cycle after its gnt, with m_rdata matching previously written 0xDEADBEEF/0xCAFEBABE/0x12345678.
- Byte-enable passthrough:
  - Stimulus: req1 writes 0x0100 data 0x0000BB00 be=4'b0010 over 0x000000AA, then reads 0x0100.
  - Required response: m_rdata=0x0000BBAA. No rvalid for the write.
- MBIST sequencing:
  - Stimulus: mbist_start=1 while req0 is held.
  - Required response: gnt0 held off; mbist_en=1 until mbist_done; bist_done pulses once; bist_fail=0; mbist_en=0. After mbist_start drops, req0 is granted.
- Retention:
  - Stimulus: sleep_req=1 while mbist_start=1 and req2 is active.
  - Required response: RET wins; ret_en=1, sleep_ack=1, no grants. After sleep_req=0, one WAKE cycle, then gnt2.
- Reset mid-MBIST:
  - Stimulus: rst_n=0 asserted between clock edges during MBIST.
  - Required response: mbist_en=0 immediately; all outputs 0; after release the state is ARB and the pointer is 0.
- Aging (ARB_AGING_EN, AGE_LIMIT=4):
  - Stimulus: sram_ready toggling with req0 and req1 contending.
  - Required response: any requester reaching 4 wait cycles is granted on the next ready cycle.
